// File: rtl/tfhe_pu_status_leds.sv
// Board status LED driver for the TFHE processing unit: lamp test after reset,
// then heartbeat, bring-up flags, stretched AXI activity, busy and sticky error.
module tfhe_pu_status_leds #(
    parameter int HEARTBEAT_DIV  = 50_000_000,
    parameter int STRETCH_CYCLES = 5_000_000,
    parameter int LAMP_CYCLES    = 100_000_000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pcie_link_up,
    input  logic [1:0] hbm_cal_done,
    input  logic       axi_rd_act,
    input  logic       axi_wr_act,
    input  logic       pu_busy,
    input  logic       err_pulse,
    input  logic       err_clear,
    output logic [7:0] leds,
    output logic [7:0] err_count
);

    localparam int LAMP_W = $clog2(LAMP_CYCLES + 1);
    localparam int HB_W   = $clog2(HEARTBEAT_DIV);
    localparam int STR_W  = $clog2(STRETCH_CYCLES + 1);
    localparam int N_SYNC = 3;
    localparam int N_STR  = 2;

    typedef enum logic {
        S_LAMP,
        S_RUN
    } state_t;

    state_t state_q, state_d;

    logic [LAMP_W-1:0] lamp_cnt;
    logic [HB_W-1:0]   hb_cnt;
    logic              hb;
    logic              busy_q;
    logic              err_sticky;
    logic [7:0]        leds_d;

    // Asynchronous level inputs: bit 0 = PCIe link, bits 2:1 = HBM stacks
    logic [N_SYNC-1:0]      async_in;
    logic [N_SYNC-1:0]      sync_out;
    logic [SYNC_STAGES-1:0] sync_ff [N_SYNC];

    assign async_in = {hbm_cal_done, pcie_link_up};

    for (genvar g = 0; g < N_SYNC; g++) begin : g_sync
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_ff[g] <= '0;
            end else begin
                sync_ff[g] <= {sync_ff[g][SYNC_STAGES-2:0], async_in[g]};
            end
        end
        assign sync_out[g] = sync_ff[g][SYNC_STAGES-1];
    end

    // Activity stretchers: bit 0 = read, bit 1 = write; a pulse (re)loads
    logic [N_STR-1:0] act_in;
    logic [N_STR-1:0] str_led;
    logic [STR_W-1:0] str_cnt [N_STR];

    assign act_in = {axi_wr_act, axi_rd_act};

    for (genvar g = 0; g < N_STR; g++) begin : g_str
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                str_cnt[g] <= '0;
            end else if (act_in[g]) begin
                str_cnt[g] <= STR_W'(STRETCH_CYCLES);
            end else if (str_cnt[g] != '0) begin
                str_cnt[g] <= str_cnt[g] - 1'b1;
            end
        end
        assign str_led[g] = (str_cnt[g] != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LAMP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        leds_d  = {err_sticky, busy_q, str_led[1], str_led[0],
                   sync_out[2], sync_out[1], sync_out[0], hb};
        case (state_q)
            S_LAMP: begin
                leds_d = 8'hFF;
                if (lamp_cnt == LAMP_W'(LAMP_CYCLES - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_LAMP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lamp_cnt <= '0;
        end else if (state_q == S_LAMP) begin
            lamp_cnt <= lamp_cnt + 1'b1;
        end
    end

    // Held in reset during the lamp test so the first RUN half-period is full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt <= '0;
            hb     <= 1'b0;
        end else if (state_q == S_LAMP) begin
            hb_cnt <= '0;
            hb     <= 1'b0;
        end else if (hb_cnt == HB_W'(HEARTBEAT_DIV - 1)) begin
            hb_cnt <= '0;
            hb     <= ~hb;
        end else begin
            hb_cnt <= hb_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= pu_busy;
        end
    end

    // A set coinciding with a clear restarts the count at one event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
            err_count  <= 8'h00;
        end else if (err_pulse) begin
            err_sticky <= 1'b1;
            if (err_clear) begin
                err_count <= 8'h01;
            end else if (err_count != 8'hFF) begin
                err_count <= err_count + 8'h01;
            end
        end else if (err_clear) begin
            err_sticky <= 1'b0;
            err_count  <= 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds <= 8'h00;
        end else begin
            leds <= leds_d;
        end
    end

endmodule

// File: tb/tb_tfhe_pu_status_leds.sv
// Directed bench for tfhe_pu_status_leds with shortened timing parameters.
module tb_tfhe_pu_status_leds;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pcie_link_up;
    logic [1:0] hbm_cal_done;
    logic       axi_rd_act;
    logic       axi_wr_act;
    logic       pu_busy;
    logic       err_pulse;
    logic       err_clear;
    logic [7:0] leds;
    logic [7:0] err_count;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    tfhe_pu_status_leds #(
        .HEARTBEAT_DIV (4),
        .STRETCH_CYCLES(3),
        .LAMP_CYCLES   (5),
        .SYNC_STAGES   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pcie_link_up(pcie_link_up),
        .hbm_cal_done(hbm_cal_done),
        .axi_rd_act  (axi_rd_act),
        .axi_wr_act  (axi_wr_act),
        .pu_busy     (pu_busy),
        .err_pulse   (err_pulse),
        .err_clear   (err_clear),
        .leds        (leds),
        .err_count   (err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle just past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        pcie_link_up = 1'b0;
        hbm_cal_done = 2'b00;
        axi_rd_act   = 1'b0;
        axi_wr_act   = 1'b0;
        pu_busy      = 1'b0;
        err_pulse    = 1'b0;
        err_clear    = 1'b0;

        // reset and lamp test
        repeat (3) tick();
        chk("rst_leds", leds, 8'h00);
        chk("rst_errcnt", err_count, 8'h00);
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("lamp_e%0d", i), leds, 8'hFF);
        end
        // heartbeat: low 4, high 4, low 4 from first RUN edge
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 0) chk("run_first", leds, 8'h00);
            chk($sformatf("hb_%0d", i), leds[0], 32'((i / 4) % 2));
        end

        // reset asserts asynchronously, mid-run and mid-lamp
        rst_n = 1'b0;
        #1;
        chk("rst_async_run", leds, 8'h00);
        rst_n = 1'b1;
        tick();
        tick();
        chk("lamp_restart", leds, 8'hFF);
        rst_n = 1'b0;
        #1;
        chk("rst_async_lamp", leds, 8'h00);
        rst_n = 1'b1;

        // events during lamp
        tick();
        chk("lamp2_e1", leds, 8'hFF);
        err_pulse  = 1'b1;
        axi_rd_act = 1'b1;
        tick();
        err_pulse  = 1'b0;
        axi_rd_act = 1'b0;
        chk("lamp2_e2", leds, 8'hFF);
        chk("lamp_errcnt", err_count, 8'h01);
        for (int i = 3; i <= 5; i++) begin
            tick();
            chk($sformatf("lamp2_e%0d", i), leds, 8'hFF);
        end
        tick();
        chk("lamp_exit", leds, 8'h80);

        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("clr0_cnt", err_count, 8'h00);
        tick();
        chk("clr0_led", leds[7], 1'b0);

        // bring-up levels
        pcie_link_up = 1'b1;
        tick(); chk("link_up_e1", leds[1], 1'b0);
        tick(); chk("link_up_e2", leds[1], 1'b0);
        tick(); chk("link_up_e3", leds[1], 1'b1);
        hbm_cal_done = 2'b10;
        tick(); chk("hbm_e1", leds[3:2], 2'b00);
        tick(); chk("hbm_e2", leds[3:2], 2'b00);
        tick(); chk("hbm_e3", leds[3:2], 2'b10);
        pcie_link_up = 1'b0;
        tick(); chk("link_dn_e1", leds[1], 1'b1);
        tick(); chk("link_dn_e2", leds[1], 1'b1);
        tick(); chk("link_dn_e3", leds[1], 1'b0);

        // single read pulse
        axi_rd_act = 1'b1;
        tick();
        axi_rd_act = 1'b0;
        chk("rd_N", leds[4], 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("rd_N%0d", i), leds[4], 1'b1);
        end
        tick();
        chk("rd_N4", leds[4], 1'b0);

        // retrigger two edges after the first pulse
        axi_rd_act = 1'b1;
        tick();
        axi_rd_act = 1'b0;
        tick();
        chk("rt_N1", leds[4], 1'b1);
        axi_rd_act = 1'b1;
        tick();
        axi_rd_act = 1'b0;
        chk("rt_N2", leds[4], 1'b1);
        for (int i = 3; i <= 5; i++) begin
            tick();
            chk($sformatf("rt_N%0d", i), leds[4], 1'b1);
        end
        tick();
        chk("rt_N6", leds[4], 1'b0);

        // write pulses every cycle for 10 cycles
        axi_wr_act = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("wr_on%0d", i), leds[5], (i > 0) ? 1'b1 : 1'b0);
        end
        axi_wr_act = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("wr_tail%0d", i), leds[5], 1'b1);
        end
        tick();
        chk("wr_off", leds[5], 1'b0);

        // error sticky and count
        err_pulse = 1'b1;
        repeat (3) tick();
        err_pulse = 1'b0;
        chk("err3_cnt", err_count, 8'd3);
        tick();
        chk("err3_led", leds[7], 1'b1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("clr_cnt", err_count, 8'd0);
        tick();
        chk("clr_led", leds[7], 1'b0);
        err_pulse = 1'b1;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        err_pulse = 1'b0;
        chk("both_cnt", err_count, 8'd1);
        tick();
        chk("both_led", leds[7], 1'b1);
        err_pulse = 1'b1;
        repeat (253) tick();
        chk("sat_254", err_count, 8'd254);
        repeat (47) tick();
        err_pulse = 1'b0;
        chk("sat_255", err_count, 8'd255);

        // busy
        pu_busy = 1'b1;
        tick(); chk("busy_e1", leds[6], 1'b0);
        tick(); chk("busy_e2", leds[6], 1'b1);
        pu_busy = 1'b0;
        tick(); chk("idle_e1", leds[6], 1'b1);
        tick(); chk("idle_e2", leds[6], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
